// File: rtl/conv_feeder.sv
// Stream sequencer feeding the folded 8-bit signed MAC from fmap/weight memories.
// Optional stall input is enabled by defining CONV_FEED_STALL_EN.
module conv_feeder #(
  parameter int KSIZE  = 9,
  parameter int NWIN   = 4,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef CONV_FEED_STALL_EN
  input  logic              stall,
`endif
  output logic [ADDR_W-1:0] fmap_addr,
  input  logic signed [7:0] fmap_rdata,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic signed [7:0] weight_rdata,
  output logic signed [7:0] data_fmaps,
  output logic signed [7:0] data_weight,
  output logic              worken,
  output logic              outputen,
  output logic              busy,
  output logic              result_valid,
  output logic [ADDR_W-1:0] win_idx,
  output logic              done
);

  localparam int TAP_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [TAP_W-1:0]  tap;
  logic [WIN_W-1:0]  win;
  logic [ADDR_W-1:0] fbase;
  logic [ADDR_W-1:0] res_cnt;
  logic              hold;
  logic              tap_last, win_last;
  logic              issue, issue_oe, issue_push, issue_flush;
  logic              wk_q, oe_q, flush_q, push_q;

`ifdef CONV_FEED_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign tap_last = (tap == TAP_W'(KSIZE - 1));
  assign win_last = (win == WIN_W'(NWIN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Stall only gates beat issue (RUN/FLUSH); DONE always advances so that
  // done stays aligned with the flush result already in the pipeline.
  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    issue_oe    = 1'b0;
    issue_push  = 1'b0;
    issue_flush = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (!hold) begin
          issue      = 1'b1;
          issue_oe   = (tap == '0);
          issue_push = (tap == '0) && (win != '0);
          if (tap_last && win_last) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!hold) begin
          issue       = 1'b1;
          issue_oe    = 1'b1;
          issue_push  = 1'b1;
          issue_flush = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Window base advances by STRIDE at each tap wrap instead of win*STRIDE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap   <= '0;
      win   <= '0;
      fbase <= '0;
    end else if (issue && (state == S_RUN)) begin
      if (tap_last) begin
        tap <= '0;
        if (win_last) begin
          win   <= '0;
          fbase <= '0;
        end else begin
          win   <= win + WIN_W'(1);
          fbase <= fbase + ADDR_W'(STRIDE);
        end
      end else begin
        tap <= tap + TAP_W'(1);
      end
    end
  end

  assign fmap_addr   = fbase + ADDR_W'(tap);
  assign weight_addr = ADDR_W'(tap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wk_q         <= 1'b0;
      oe_q         <= 1'b0;
      flush_q      <= 1'b0;
      push_q       <= 1'b0;
      result_valid <= 1'b0;
      win_idx      <= '0;
      res_cnt      <= '0;
      done         <= 1'b0;
    end else begin
      wk_q         <= issue;
      oe_q         <= issue_oe;
      flush_q      <= issue_flush;
      push_q       <= issue_push;
      result_valid <= push_q;
      done         <= (state == S_DONE);
      if ((state == S_IDLE) && start) res_cnt <= '0;
      else if (push_q)                res_cnt <= res_cnt + ADDR_W'(1);
      if (push_q) win_idx <= res_cnt;
    end
  end

  assign worken      = wk_q;
  assign outputen    = oe_q;
  assign data_fmaps  = (wk_q && !flush_q) ? fmap_rdata   : '0;
  assign data_weight = (wk_q && !flush_q) ? weight_rdata : '0;
  assign busy        = (state != S_IDLE) || done;

endmodule

// File: tb/tb_conv_feeder.sv
// Directed self-checking bench for conv_feeder with a behavioural MAC and memories.
`timescale 1ns/1ps
module tb_conv_feeder;

  logic clk = 1'b0;
  logic rst;
  logic start3, start9;
`ifdef CONV_FEED_STALL_EN
  logic stall3, stall9;
`endif
  always #5 clk = ~clk;

  logic [7:0]        fa3, wa3, wi3, fa9, wa9, wi9;
  logic signed [7:0] fr3, wr3, df3, dw3, fr9, wr9, df9, dw9;
  logic              wk3, oe3, busy3, rv3, done3;
  logic              wk9, oe9, busy9, rv9, done9;

  conv_feeder #(.KSIZE(3), .NWIN(2), .STRIDE(1), .ADDR_W(8)) u3 (
    .clk(clk), .rst(rst), .start(start3),
`ifdef CONV_FEED_STALL_EN
    .stall(stall3),
`endif
    .fmap_addr(fa3), .fmap_rdata(fr3), .weight_addr(wa3), .weight_rdata(wr3),
    .data_fmaps(df3), .data_weight(dw3), .worken(wk3), .outputen(oe3),
    .busy(busy3), .result_valid(rv3), .win_idx(wi3), .done(done3));

  conv_feeder #(.KSIZE(9), .NWIN(1), .STRIDE(1), .ADDR_W(8)) u9 (
    .clk(clk), .rst(rst), .start(start9),
`ifdef CONV_FEED_STALL_EN
    .stall(stall9),
`endif
    .fmap_addr(fa9), .fmap_rdata(fr9), .weight_addr(wa9), .weight_rdata(wr9),
    .data_fmaps(df9), .data_weight(dw9), .worken(wk9), .outputen(oe9),
    .busy(busy9), .result_valid(rv9), .win_idx(wi9), .done(done9));

  // synchronous-read memories
  logic signed [7:0] fmem3 [256];
  logic signed [7:0] wmem3 [256];
  logic signed [7:0] fmem9 [256];
  logic signed [7:0] wmem9 [256];
  always @(posedge clk) begin
    fr3 <= fmem3[fa3];
    wr3 <= wmem3[wa3];
    fr9 <= fmem9[fa9];
    wr9 <= wmem9[wa9];
  end

  // folded MAC: outputen pushes acc_temp into acc and restarts acc_temp
  logic signed [20:0] acc3, tmp3, acc9, tmp9;
  logic signed [15:0] prod3, prod9;
  assign prod3 = df3 * dw3;
  assign prod9 = df9 * dw9;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc3 <= '0; tmp3 <= '0; acc9 <= '0; tmp9 <= '0;
    end else begin
      if (wk3) begin
        if (oe3) begin acc3 <= tmp3; tmp3 <= prod3; end
        else tmp3 <= tmp3 + prod3;
      end
      if (wk9) begin
        if (oe9) begin acc9 <= tmp9; tmp9 <= prod9; end
        else tmp9 <= tmp9 + prod9;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   r3_acc [64];
  int   r3_idx [64];
  int   r3_cyc [64];
  int   d3_cyc [64];
  int   r3_n = 0, d3_n = 0;
  int   r9_acc [64];
  int   r9_idx [64];
  int   d9_cyc [64];
  int   r9_n = 0, d9_n = 0;
  logic wk_h   [4096];
  logic oe_h   [4096];
  logic busy_h [4096];
  logic [7:0] fa_h [4096];
  logic [7:0] wa_h [4096];

  always @(negedge clk) begin
    if (cyc < 4096) begin
      wk_h[cyc]   <= wk3;
      oe_h[cyc]   <= oe3;
      busy_h[cyc] <= busy3;
      fa_h[cyc]   <= fa3;
      wa_h[cyc]   <= wa3;
    end
    if (rv3 && r3_n < 64) begin
      r3_acc[r3_n] <= int'(acc3);
      r3_idx[r3_n] <= int'(wi3);
      r3_cyc[r3_n] <= cyc;
      r3_n <= r3_n + 1;
    end
    if (done3 && d3_n < 64) begin
      d3_cyc[d3_n] <= cyc;
      d3_n <= d3_n + 1;
    end
    if (rv9 && r9_n < 64) begin
      r9_acc[r9_n] <= int'(acc9);
      r9_idx[r9_n] <= int'(wi9);
      r9_n <= r9_n + 1;
    end
    if (done9 && d9_n < 64) begin
      d9_cyc[d9_n] <= cyc;
      d9_n <= d9_n + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic run_start(input bit sel, output int t0);
    if (sel) start9 = 1'b1;
    else     start3 = 1'b1;
    t0 = cyc + 1;
    tick();
    start3 = 1'b0;
    start9 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int base, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if ((sel ? d9_n : d3_n) > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_basic3();
    fmem3[0] = 8'sd1; fmem3[1] = 8'sd2; fmem3[2] = 8'sd3; fmem3[3] = 8'sd4;
    wmem3[0] = 8'sd1; wmem3[1] = 8'sd1; wmem3[2] = 8'sd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start3 = 1'b0; start9 = 1'b0;
`ifdef CONV_FEED_STALL_EN
    stall3 = 1'b0; stall9 = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      fmem3[i] = '0; wmem3[i] = '0; fmem9[i] = '0; wmem9[i] = '0;
    end
    tick(); tick(); tick();
    total++;
    if ({fa3, wa3} !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", {fa3, wa3}); end
    total++;
    if ({df3, dw3} !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", {df3, dw3}); end
    total++;
    if ({wk3, oe3, busy3, rv3, done3} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {wk3, oe3, busy3, rv3, done3});
    end
    total++;
    if (wi3 !== 8'd0) begin bad++; $display("FAIL reset_win_idx got=%0d exp=0", wi3); end
    rst = 1'b0;
    tick(); tick();
    total++;
    if ({wk3, oe3, busy3, rv3, done3, wk9, busy9, done9} !== 8'b0) begin
      bad++; $display("FAIL idle_ctrl got=%b exp=00000000", {wk3, oe3, busy3, rv3, done3, wk9, busy9, done9});
    end
  endtask

  task automatic test_basic();
    int t0, b, db;
    bit ok;
    logic [31:0] m_wk, m_oe, m_busy;
    logic [47:0] s_fa, s_wa;
    load_basic3();
    b = r3_n; db = d3_n;
    run_start(1'b0, t0);
    wait_done(1'b0, db, 40, ok);
    goto_cyc(t0 + 12);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL basic_timeout got=%0d exp=1", ok); end
    total++;
    if (r3_n - b !== 2) begin bad++; $display("FAIL basic_result_count got=%0d exp=2", r3_n - b); end
    total++;
    if (r3_acc[b] !== 6) begin bad++; $display("FAIL basic_acc0 got=%0d exp=6", r3_acc[b]); end
    total++;
    if (r3_idx[b] !== 0) begin bad++; $display("FAIL basic_idx0 got=%0d exp=0", r3_idx[b]); end
    total++;
    if (r3_cyc[b] - t0 !== 5) begin bad++; $display("FAIL basic_rv0_cycle got=%0d exp=5", r3_cyc[b] - t0); end
    total++;
    if (r3_acc[b+1] !== 9) begin bad++; $display("FAIL basic_acc1 got=%0d exp=9", r3_acc[b+1]); end
    total++;
    if (r3_idx[b+1] !== 1) begin bad++; $display("FAIL basic_idx1 got=%0d exp=1", r3_idx[b+1]); end
    total++;
    if (r3_cyc[b+1] - t0 !== 8) begin bad++; $display("FAIL basic_rv1_cycle got=%0d exp=8", r3_cyc[b+1] - t0); end
    total++;
    if (d3_cyc[db] - t0 !== 8) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=8", d3_cyc[db] - t0); end
    m_wk = '0; m_oe = '0; m_busy = '0;
    for (int i = 0; i <= 10; i++) begin
      m_wk[i] = wk_h[t0+i]; m_oe[i] = oe_h[t0+i]; m_busy[i] = busy_h[t0+i];
    end
    total++;
    if (m_wk !== 32'h0FE) begin bad++; $display("FAIL basic_worken got=%h exp=000000fe", m_wk); end
    total++;
    if (m_oe !== 32'h092) begin bad++; $display("FAIL basic_outputen got=%h exp=00000092", m_oe); end
    total++;
    if (m_busy !== 32'h1FF) begin bad++; $display("FAIL basic_busy got=%h exp=000001ff", m_busy); end
    s_fa = '0; s_wa = '0;
    for (int i = 0; i < 6; i++) begin
      s_fa = {s_fa[39:0], fa_h[t0+i]};
      s_wa = {s_wa[39:0], wa_h[t0+i]};
    end
    total++;
    if (s_fa !== 48'h000102010203) begin bad++; $display("FAIL basic_fmap_addr got=%h exp=000102010203", s_fa); end
    total++;
    if (s_wa !== 48'h000102000102) begin bad++; $display("FAIL basic_weight_addr got=%h exp=000102000102", s_wa); end
    total++;
    if (tmp3 !== 21'sd0) begin bad++; $display("FAIL basic_flush_acc_temp got=%0d exp=0", tmp3); end
  endtask

  task automatic test_extremes();
    int t0, b, db;
    bit ok;
    for (int i = 0; i < 9; i++) begin fmem9[i] = -8'sd128; wmem9[i] = -8'sd128; end
    b = r9_n; db = d9_n;
    run_start(1'b1, t0);
    wait_done(1'b1, db, 40, ok);
    tick();
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL ext_timeout got=%0d exp=1", ok); end
    total++;
    if (r9_n - b !== 1) begin bad++; $display("FAIL ext_result_count got=%0d exp=1", r9_n - b); end
    total++;
    if (r9_acc[b] !== 147456) begin bad++; $display("FAIL ext_acc_max got=%0d exp=147456", r9_acc[b]); end
    total++;
    if (d9_cyc[db] - t0 !== 11) begin bad++; $display("FAIL ext_done_cycle got=%0d exp=11", d9_cyc[db] - t0); end
    for (int i = 0; i < 9; i++) wmem9[i] = 8'sd127;
    b = r9_n; db = d9_n;
    run_start(1'b1, t0);
    wait_done(1'b1, db, 40, ok);
    tick();
    total++;
    if (r9_acc[b] !== -146304) begin bad++; $display("FAIL ext_acc_min got=%0d exp=-146304", r9_acc[b]); end
    total++;
    if (r9_idx[b] !== 0) begin bad++; $display("FAIL ext_idx got=%0d exp=0", r9_idx[b]); end
  endtask

  task automatic test_back_to_back();
    int t0, t1, b, db, n;
    bit ok;
    load_basic3();
    b = r3_n; db = d3_n;
    run_start(1'b0, t0);
    n = 0;
    while (done3 !== 1'b1 && n < 40) begin tick(); n++; end
    total++;
    if (done3 !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%0d exp=1", done3); end
    // second run requested in the done cycle, with new weights
    wmem3[0] = 8'sd2; wmem3[1] = 8'sd0; wmem3[2] = 8'sd1;
    run_start(1'b0, t1);
    wait_done(1'b0, db + 1, 40, ok);
    tick();
    total++;
    if (r3_n - b !== 4) begin bad++; $display("FAIL b2b_result_count got=%0d exp=4", r3_n - b); end
    total++;
    if (r3_acc[b+1] !== 9) begin bad++; $display("FAIL b2b_run1_acc1 got=%0d exp=9", r3_acc[b+1]); end
    total++;
    if (r3_acc[b+2] !== 5) begin bad++; $display("FAIL b2b_run2_acc0 got=%0d exp=5", r3_acc[b+2]); end
    total++;
    if (r3_idx[b+2] !== 0) begin bad++; $display("FAIL b2b_run2_idx0 got=%0d exp=0", r3_idx[b+2]); end
    total++;
    if (r3_cyc[b+2] - t1 !== 5) begin bad++; $display("FAIL b2b_run2_rv0_cycle got=%0d exp=5", r3_cyc[b+2] - t1); end
    total++;
    if (r3_acc[b+3] !== 8) begin bad++; $display("FAIL b2b_run2_acc1 got=%0d exp=8", r3_acc[b+3]); end
    total++;
    if (d3_cyc[db+1] - t1 !== 8) begin bad++; $display("FAIL b2b_run2_done_cycle got=%0d exp=8", d3_cyc[db+1] - t1); end
  endtask

  task automatic test_reset_midrun();
    int t0, b, db;
    bit ok;
    load_basic3();
    b = r3_n; db = d3_n;
    run_start(1'b0, t0);
    goto_cyc(t0 + 4);
    rst = 1'b1;
    #1;
    total++;
    if ({wk3, oe3, busy3} !== 3'b000) begin bad++; $display("FAIL midrst_ctrl got=%b exp=000", {wk3, oe3, busy3}); end
    tick();
    rst = 1'b0;
    goto_cyc(t0 + 20);
    total++;
    if (d3_n !== db) begin bad++; $display("FAIL midrst_no_done got=%0d exp=%0d", d3_n, db); end
    total++;
    if (r3_n !== b) begin bad++; $display("FAIL midrst_no_result got=%0d exp=%0d", r3_n, b); end
    run_start(1'b0, t0);
    wait_done(1'b0, db, 40, ok);
    tick();
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL midrst_restart_timeout got=%0d exp=1", ok); end
    total++;
    if (r3_acc[b] !== 6 || r3_acc[b+1] !== 9) begin
      bad++; $display("FAIL midrst_restart_acc got=%0d,%0d exp=6,9", r3_acc[b], r3_acc[b+1]);
    end
  endtask

  task automatic test_start_ignored();
    int t0, b, db;
    logic [31:0] m_wk;
    load_basic3();
    b = r3_n; db = d3_n;
    run_start(1'b0, t0);
    goto_cyc(t0 + 2);
    start3 = 1'b1; tick(); start3 = 1'b0;
    goto_cyc(t0 + 7);
    start3 = 1'b1; tick(); start3 = 1'b0;
    goto_cyc(t0 + 18);
    total++;
    if (d3_n - db !== 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", d3_n - db); end
    total++;
    if (r3_n - b !== 2) begin bad++; $display("FAIL ign_result_count got=%0d exp=2", r3_n - b); end
    total++;
    if (r3_acc[b] !== 6 || r3_acc[b+1] !== 9) begin
      bad++; $display("FAIL ign_acc got=%0d,%0d exp=6,9", r3_acc[b], r3_acc[b+1]);
    end
    m_wk = '0;
    for (int i = 0; i <= 16; i++) m_wk[i] = wk_h[t0+i];
    total++;
    if (m_wk !== 32'h0FE) begin bad++; $display("FAIL ign_worken got=%h exp=000000fe", m_wk); end
  endtask

`ifdef CONV_FEED_STALL_EN
  task automatic test_stall();
    int t0, b, db;
    bit ok;
    logic [31:0] m_wk;
    load_basic3();
    b = r3_n; db = d3_n;
    run_start(1'b0, t0);
    goto_cyc(t0 + 4);
    stall3 = 1'b1;
    goto_cyc(t0 + 7);
    stall3 = 1'b0;
    wait_done(1'b0, db, 40, ok);
    goto_cyc(t0 + 14);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL stall_timeout got=%0d exp=1", ok); end
    total++;
    if (r3_acc[b] !== 6 || r3_acc[b+1] !== 9) begin
      bad++; $display("FAIL stall_acc got=%0d,%0d exp=6,9", r3_acc[b], r3_acc[b+1]);
    end
    total++;
    if (r3_cyc[b+1] - t0 !== 11) begin bad++; $display("FAIL stall_rv1_cycle got=%0d exp=11", r3_cyc[b+1] - t0); end
    total++;
    if (d3_cyc[db] - t0 !== 11) begin bad++; $display("FAIL stall_done_cycle got=%0d exp=11", d3_cyc[db] - t0); end
    m_wk = '0;
    for (int i = 0; i <= 12; i++) m_wk[i] = wk_h[t0+i];
    total++;
    if (m_wk !== 32'h71E) begin bad++; $display("FAIL stall_worken got=%h exp=0000071e", m_wk); end
    total++;
    if (fa_h[t0+5] !== 8'd2 || fa_h[t0+7] !== 8'd2) begin
      bad++; $display("FAIL stall_addr_hold got=%0d,%0d exp=2,2", fa_h[t0+5], fa_h[t0+7]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_reset_midrun();
    test_start_ignored();
`ifdef CONV_FEED_STALL_EN
    test_stall();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
